// File: rtl/puf_challenge_sequencer.sv
// Challenge/response sequencer for the memristive PUF core. Per request it resets the PUF,
// applies the latched challenge for a settle window, captures the response N_REPEAT times,
// then reports the first response, its stability and its distance to an expected value.
module puf_challenge_sequencer #(
    parameter int unsigned N_CHAL        = 8,
    parameter int unsigned N_RESP        = 8,
    parameter int unsigned SETTLE_CYCLES = 20,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned N_REPEAT      = 2,
    parameter int unsigned MAX_HD        = 0,
    localparam int unsigned HD_W         = $clog2(N_RESP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_CHAL-1:0] chal_in,
    input  logic [N_RESP-1:0] exp_resp,
    input  logic              exp_valid,
    output logic [N_CHAL-1:0] puf_C,
    output logic              puf_vin_valid,
    output logic              puf_rst_n,
    input  logic [N_RESP-1:0] puf_R,
    output logic              busy,
    output logic              done,
    output logic [N_RESP-1:0] resp_out,
    output logic              stable,
    output logic              match,
    output logic [HD_W-1:0]   hd_out
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned REP_W   = $clog2(N_REPEAT + 1);

    typedef enum logic [2:0] {StIdle, StPrst, StSettle, StCompare, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q;
    logic [REP_W-1:0]  rep_q;
    logic [N_CHAL-1:0] chal_q;
    logic [N_RESP-1:0] exp_q;
    logic              exp_valid_q;
    logic              differ_q;
    logic [N_RESP-1:0] resp_q;
    logic              vin_q, rst_n_q, busy_q, done_q, stable_q, match_q;
    logic [HD_W-1:0]   hd_q;

    logic              last_gap, last_settle, last_rep;
    logic              accept, cancel, capture;
    logic [HD_W-1:0]   hd_calc;

    function automatic logic [HD_W-1:0] popcount(input logic [N_RESP-1:0] v);
        logic [HD_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_RESP); i++) begin
            c = c + HD_W'(v[i]);
        end
        return c;
    endfunction

    // Decode counter terminal counts and request-level events.
    always_comb begin
        last_gap    = (cyc_q == CNT_W'(GAP_CYCLES - 1));
        last_settle = (cyc_q == CNT_W'(SETTLE_CYCLES - 1));
        last_rep    = (rep_q == REP_W'(N_REPEAT - 1));
        accept      = (state_q == StIdle) && start && !abort;
        cancel      = (state_q != StIdle) && abort;
        capture     = (state_q == StSettle) && last_settle && !abort;
        hd_calc     = popcount(resp_q ^ exp_q);
    end

    // Next-state logic; abort returns to idle from any active state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StPrst;
            StPrst: begin
                if (abort)         state_d = StIdle;
                else if (last_gap) state_d = StSettle;
            end
            StSettle: begin
                if (abort)            state_d = StIdle;
                else if (last_settle) state_d = last_rep ? StCompare : StPrst;
            end
            StCompare: state_d = abort ? StIdle : StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Phase cycle counter restarts on every state change; repeat counter counts captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            rep_q <= '0;
        end else begin
            if (state_d != state_q || !(state_q == StPrst || state_q == StSettle)) begin
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            if (state_q == StIdle || cancel) begin
                rep_q <= '0;
            end else if (capture) begin
                rep_q <= rep_q + REP_W'(1);
            end
        end
    end

    // Registered outputs and datapath; PUF controls follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chal_q      <= '0;
            exp_q       <= '0;
            exp_valid_q <= 1'b0;
            differ_q    <= 1'b0;
            resp_q      <= '0;
            vin_q       <= 1'b0;
            rst_n_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stable_q    <= 1'b0;
            match_q     <= 1'b0;
            hd_q        <= '0;
        end else begin
            rst_n_q <= (state_d != StPrst);
            vin_q   <= (state_d == StSettle);
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            if (accept) begin
                chal_q      <= chal_in;
                exp_q       <= exp_resp;
                exp_valid_q <= exp_valid;
                differ_q    <= 1'b0;
                stable_q    <= 1'b0;
                match_q     <= 1'b0;
                hd_q        <= '0;
            end
            if (cancel) begin
                differ_q <= 1'b0;
                resp_q   <= '0;
                stable_q <= 1'b0;
                match_q  <= 1'b0;
                hd_q     <= '0;
            end
            if (capture) begin
                if (rep_q == '0)          resp_q   <= puf_R;
                else if (puf_R != resp_q) differ_q <= 1'b1;
            end
            if (state_q == StCompare && !abort) begin
                hd_q     <= hd_calc;
                match_q  <= exp_valid_q && (32'(hd_calc) <= MAX_HD);
                stable_q <= !differ_q;
            end
        end
    end

    assign puf_C         = chal_q;
    assign puf_vin_valid = vin_q;
    assign puf_rst_n     = rst_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign resp_out      = resp_q;
    assign stable        = stable_q;
    assign match         = match_q;
    assign hd_out        = hd_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: behavioural PUF, timeline-based reference model,
// per-cycle compare of two instances (MAX_HD=0 and MAX_HD=1), directed and random requests.
module tb_puf_challenge_sequencer;

    localparam int G    = 4;
    localparam int S    = 20;
    localparam int NREP = 2;
    localparam int P    = G + S;
    localparam int L    = NREP * P + 2;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] chal_in;
    logic [7:0] exp_resp;
    logic       exp_valid;

    logic [7:0] d_c    [2];
    logic [7:0] d_r    [2];
    logic [7:0] d_resp [2];
    logic [3:0] d_hd   [2];
    logic [1:0] d_vin, d_rstn, d_busy, d_done, d_stable, d_match;

    // PUF knobs: mask applied to every application after the first, glitch mid-settle.
    logic [7:0] mask_k   = 8'h00;
    logic       glitch_k = 1'b0;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    puf_challenge_sequencer #(.MAX_HD(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chal_in(chal_in),
        .exp_resp(exp_resp), .exp_valid(exp_valid), .puf_C(d_c[0]),
        .puf_vin_valid(d_vin[0]), .puf_rst_n(d_rstn[0]), .puf_R(d_r[0]), .busy(d_busy[0]),
        .done(d_done[0]), .resp_out(d_resp[0]), .stable(d_stable[0]), .match(d_match[0]),
        .hd_out(d_hd[0])
    );

    puf_challenge_sequencer #(.MAX_HD(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .chal_in(chal_in),
        .exp_resp(exp_resp), .exp_valid(exp_valid), .puf_C(d_c[1]),
        .puf_vin_valid(d_vin[1]), .puf_rst_n(d_rstn[1]), .puf_R(d_r[1]), .busy(d_busy[1]),
        .done(d_done[1]), .resp_out(d_resp[1]), .stable(d_stable[1]), .match(d_match[1]),
        .hd_out(d_hd[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Nominal PUF transfer function.
    function automatic logic [7:0] puf_f(input logic [7:0] c);
        if (c == 8'hA9) return 8'hA5;
        return {c[3:0], c[7:4]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] puf_resp(input logic [7:0] c, input logic vin, input int sc,
                                            input logic later_app, input logic [7:0] mask,
                                            input logic glitch);
        if (!vin) return ~puf_f(c);
        if (glitch && sc == 10) return ~puf_f(c);
        return puf_f(c) ^ (later_app ? mask : 8'h00);
    endfunction

    // Behavioural PUF state: settle cycle index and whether an earlier application happened.
    int         sc [2] = '{0, 0};
    logic [1:0] seen_vin = 2'b00;
    logic [1:0] seen_gap = 2'b00;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!d_busy[i]) begin
                seen_vin[i] <= 1'b0;
                seen_gap[i] <= 1'b0;
            end else begin
                if (d_vin[i]) seen_vin[i] <= 1'b1;
                if (seen_vin[i] && !d_vin[i]) seen_gap[i] <= 1'b1;
            end
            sc[i] <= d_vin[i] ? sc[i] + 1 : 0;
        end
    end

    assign d_r[0] = puf_resp(d_c[0], d_vin[0], sc[0], seen_gap[0], mask_k, glitch_k);
    assign d_r[1] = puf_resp(d_c[1], d_vin[1], sc[1], seen_gap[1], mask_k, glitch_k);

    // Reference model: m_k is the cycle number within a request (0 = idle, L = done cycle).
    int         m_k    = 0;
    bit         m_up   = 1'b0;
    logic [7:0] m_chal = 8'h00;
    logic [7:0] m_exp  = 8'h00;
    bit         m_expv = 1'b0;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_resp = 8'h00;
    bit         m_stable = 1'b0;
    int         m_hd   = 0;
    bit         m_res  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k <= 0; m_up <= 1'b0; m_chal <= 8'h00; m_exp <= 8'h00; m_expv <= 1'b0;
            m_mask <= 8'h00; m_resp <= 8'h00; m_stable <= 1'b0; m_hd <= 0; m_res <= 1'b0;
        end else begin
            m_up <= 1'b1;
            if (m_k == 0) begin
                if (start && !abort) begin
                    m_k <= 1; m_chal <= chal_in; m_exp <= exp_resp; m_expv <= exp_valid;
                    m_mask <= mask_k; m_stable <= 1'b0; m_hd <= 0; m_res <= 1'b0;
                end
            end else if (abort) begin
                m_k <= 0; m_resp <= 8'h00; m_stable <= 1'b0; m_hd <= 0; m_res <= 1'b0;
            end else begin
                if (m_k == P) m_resp <= puf_f(m_chal);
                if (m_k == L - 1) begin
                    m_hd     <= $countones(puf_f(m_chal) ^ m_exp);
                    m_res    <= 1'b1;
                    m_stable <= (NREP == 1) || (m_mask == 8'h00);
                end
                m_k <= (m_k == L) ? 0 : m_k + 1;
            end
        end
    end

    task automatic check(input int inst, input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, inst, $time, act, want);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                bit in_app;
                int p;
                in_app = (m_k >= 1) && (m_k <= NREP * P);
                p      = (m_k >= 1) ? (m_k - 1) % P : 0;
                check(i, "puf_C", d_c[i], m_chal);
                check(i, "vin_valid", d_vin[i], in_app && p >= G);
                check(i, "puf_rst_n", d_rstn[i], m_up && !(in_app && p < G));
                check(i, "busy", d_busy[i], m_k != 0);
                check(i, "done", d_done[i], m_k == L);
                check(i, "resp_out", d_resp[i], m_resp);
                check(i, "stable", d_stable[i], m_stable);
                check(i, "hd_out", d_hd[i], m_hd);
                check(i, "match", d_match[i], m_res && m_expv && m_hd <= i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [7:0] c, input logic [7:0] e, input logic v,
                             input logic [7:0] m, input logic g);
        mask_k = m; glitch_k = g;
        chal_in = c; exp_resp = e; exp_valid = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From cycle 1 of a request, wait for done; report its cycle and PUF control activity.
    task automatic run_to_done(output int cyc, output int nvin, output int nlow);
        bit found;
        found = 1'b0; cyc = 0; nvin = 0; nlow = 0;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(negedge clk);
            if (d_vin[0]) nvin++;
            if (!d_rstn[0]) nlow++;
            if (d_done[0]) begin
                found = 1'b1;
                cyc = c;
            end
        end
        check(0, "done_seen", found, 1);
    endtask

    task automatic check_results(input logic [7:0] r, input int hd, input bit m0, input bit m1,
                                 input bit st);
        check(0, "lit_resp", d_resp[0], r);
        check(0, "lit_hd", d_hd[0], hd);
        check(0, "lit_match", d_match[0], m0);
        check(1, "lit_match", d_match[1], m1);
        check(0, "lit_stable", d_stable[0], st);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_rst();
        start = 1'b0; abort = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check(i, "rst_busy", d_busy[i], 0);
            check(i, "rst_done", d_done[i], 0);
            check(i, "rst_vin", d_vin[i], 0);
            check(i, "rst_rstn", d_rstn[i], 0);
            check(i, "rst_resp", d_resp[i], 0);
            check(i, "rst_match", d_match[i], 0);
            check(i, "rst_stable", d_stable[i], 0);
            check(i, "rst_hd", d_hd[i], 0);
            check(i, "rst_chal", d_c[i], 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int cyc, nvin, nlow;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chal_in = 8'h00; exp_resp = 8'h00; exp_valid = 1'b0;
        #1 rst = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check(0, "reset_busy", d_busy[0], 0);
        check(0, "reset_rstn", d_rstn[0], 0);
        check(0, "reset_chal", d_c[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        check(0, "idle_rstn", d_rstn[0], 1);
        tick();

        // Nominal request: timing and results.
        start_req(8'hA9, 8'hA5, 1'b1, 8'h00, 1'b0);
        run_to_done(cyc, nvin, nlow);
        check(0, "done_cycle", cyc, 50);
        check(0, "vin_cycles", nvin, 40);
        check(0, "rstn_low_cycles", nlow, 8);
        check_results(8'hA5, 0, 1'b1, 1'b1, 1'b1);
        tick(); tick();
        @(negedge clk);
        check(0, "hold_resp", d_resp[0], 8'hA5);
        check(0, "hold_match", d_match[0], 1);
        tick();

        // One bit off the expected value.
        start_req(8'hA9, 8'hA4, 1'b1, 8'h00, 1'b0);
        run_to_done(cyc, nvin, nlow);
        check_results(8'hA5, 1, 1'b0, 1'b1, 1'b1);
        tick();

        // Second application returns 0xAD.
        start_req(8'hA9, 8'hA5, 1'b1, 8'h08, 1'b0);
        run_to_done(cyc, nvin, nlow);
        check_results(8'hA5, 0, 1'b1, 1'b1, 1'b0);
        tick();

        // Glitch mid-settle that recovers before capture.
        start_req(8'hA9, 8'hA5, 1'b1, 8'h00, 1'b1);
        run_to_done(cyc, nvin, nlow);
        check_results(8'hA5, 0, 1'b1, 1'b1, 1'b1);
        tick();

        // No expected value supplied.
        start_req(8'hA9, 8'h00, 1'b0, 8'h00, 1'b0);
        run_to_done(cyc, nvin, nlow);
        check_results(8'hA5, 4, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset at cycle 30, then a full request.
        start_req(8'hA9, 8'hA5, 1'b1, 8'h00, 1'b0);
        repeat (29) tick();
        pulse_rst();
        start_req(8'hA9, 8'hA5, 1'b1, 8'h00, 1'b0);
        run_to_done(cyc, nvin, nlow);
        check(0, "done_cycle_after_rst", cyc, 50);
        tick();

        // Start while busy at cycle 5, abort at cycle 10.
        start_req(8'hA9, 8'hA5, 1'b1, 8'h00, 1'b0);
        repeat (4) tick();
        chal_in = 8'h3C; exp_resp = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check(0, "busy_start_chal", d_c[0], 8'hA9);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check(0, "abort_busy", d_busy[0], 0);
        check(0, "abort_done", d_done[0], 0);
        check(0, "abort_vin", d_vin[0], 0);
        check(0, "abort_rstn", d_rstn[0], 1);
        check_results(8'h00, 0, 1'b0, 1'b0, 1'b0);
        tick();

        // Abort and start together in idle.
        chal_in = 8'h55; abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check(0, "abort_start_idle", d_busy[0], 0);
        tick();

        // Random requests with busy starts, aborts and occasional resets.
        for (int r = 0; r < 40; r++) begin
            logic [7:0] c;
            logic [7:0] e;
            int         rst_at;
            bit         hit_rst;
            repeat ($urandom_range(0, 2)) tick();
            c = ($urandom_range(0, 3) == 0) ? 8'hA9 : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       e = puf_f(c);
                1:       e = puf_f(c) ^ (8'h01 << $urandom_range(0, 7));
                default: e = 8'($urandom);
            endcase
            rst_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 45)) : -1;
            hit_rst = 1'b0;
            start_req(c, e, 1'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                      1'($urandom));
            for (int k = 0; k < 120 && m_k != 0 && !hit_rst; k++) begin
                if (k == rst_at) begin
                    pulse_rst();
                    hit_rst = 1'b1;
                end else begin
                    abort = ($urandom_range(0, 99) == 0);
                    if ($urandom_range(0, 29) == 0) begin
                        start = 1'b1; chal_in = 8'($urandom); exp_resp = 8'($urandom);
                        exp_valid = 1'($urandom);
                    end
                    tick();
                    start = 1'b0; abort = 1'b0;
                end
            end
            check(0, "request_ended", (m_k == 0), 1);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
